// File: rtl/mult_mat_seq.sv
// mult_mat_seq: sequential unsigned matrix multiplier, C(NxP) = A(NxM) * B(MxP).
// One multiply-accumulate per enabled clock. The full result and the overflow
// flag are published together when the operation completes.
// Optional feature: define MULT_MAT_SAT_EN to saturate each result element at
// 2^Bit-1 instead of keeping its Bit LSBs. ovf behaves the same either way.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture operands, clear accumulator and indices
// MAC   | acc += A(i,k)*B(k,j), one k per enabled edge
// WRITE | reduce acc into C(i,j), advance (i,j)
// DONE  | result/ovf published, done pulse for one enabled cycle
module mult_mat_seq #(
    parameter int Bit = 3,
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int P   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_enable,
    input  logic               start,
    input  logic [Bit*N*M-1:0] matriz_A,
    input  logic [Bit*M*P-1:0] matriz_B,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [Bit*N*P-1:0] matriz_resultado
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = 2 * Bit;
    // Wide enough to hold M products of (2^Bit-1)^2 without wrapping.
    localparam int AW = 2 * Bit + $clog2(M + 1);
    localparam logic [AW-1:0] C_MAX = {{(AW - Bit){1'b0}}, {Bit{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [Bit*N*M-1:0] r_a;
    logic [Bit*M*P-1:0] r_b;
    logic [Bit*N*P-1:0] r_buf;
    logic [Bit*N*P-1:0] r_res;
    logic [AW-1:0]      r_acc;
    logic [IW-1:0]      r_i;
    logic [JW-1:0]      r_j;
    logic [KW-1:0]      r_k;
    logic               r_ovf_acc;
    logic               r_ovf;

    logic [Bit-1:0]     w_a_elem;
    logic [Bit-1:0]     w_b_elem;
    logic [PW-1:0]      w_prod;
    logic [Bit-1:0]     w_red;
    logic               w_elem_ovf;
    logic               w_last_k;
    logic               w_last_j;
    logic               w_last_i;
    logic [Bit*N*P-1:0] w_buf_next;

    assign w_last_k = (r_k == KW'(M - 1));
    assign w_last_j = (r_j == JW'(P - 1));
    assign w_last_i = (r_i == IW'(N - 1));

    assign matriz_resultado = r_res;
    assign ovf              = r_ovf;

    // Operand selection: A(i,k) row-major, B(k,j) column-major.
    always_comb begin
        w_a_elem = '0;
        w_b_elem = '0;
        for (int ii = 0; ii < N; ii++) begin
            for (int kk = 0; kk < M; kk++) begin
                if (r_i == IW'(ii) && r_k == KW'(kk)) begin
                    w_a_elem = r_a[(ii*M + kk)*Bit +: Bit];
                end
            end
        end
        for (int jj = 0; jj < P; jj++) begin
            for (int kk = 0; kk < M; kk++) begin
                if (r_j == JW'(jj) && r_k == KW'(kk)) begin
                    w_b_elem = r_b[(jj*M + kk)*Bit +: Bit];
                end
            end
        end
    end

    assign w_prod = PW'(w_a_elem) * PW'(w_b_elem);

    // Reduce the finished accumulator to one result element.
    always_comb begin
        w_elem_ovf = (r_acc > C_MAX);
`ifdef MULT_MAT_SAT_EN
        w_red = w_elem_ovf ? {Bit{1'b1}} : r_acc[Bit-1:0];
`else
        w_red = r_acc[Bit-1:0];
`endif
    end

    // Buffer contents including the element being written this cycle, so the
    // last element reaches the output on the same edge that enters DONE.
    always_comb begin
        w_buf_next = r_buf;
        for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < P; jj++) begin
                if (r_state == WRITE && r_i == IW'(ii) && r_j == JW'(jj)) begin
                    w_buf_next[(ii*P + jj)*Bit +: Bit] = w_red;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (clk_enable) begin
            r_state <= w_next;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = LOAD;
            end
            LOAD:  w_next = MAC;
            MAC:   if (w_last_k) w_next = WRITE;
            WRITE: w_next = (w_last_i && w_last_j) ? DONE : MAC;
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulation, indexing and result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_buf     <= '0;
            r_res     <= '0;
            r_acc     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (clk_enable) begin
            case (r_state)
                LOAD: begin
                    r_a       <= matriz_A;
                    r_b       <= matriz_B;
                    r_acc     <= '0;
                    r_i       <= '0;
                    r_j       <= '0;
                    r_k       <= '0;
                    r_ovf_acc <= 1'b0;
                end
                MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (!w_last_k) r_k <= r_k + KW'(1);
                end
                WRITE: begin
                    r_buf     <= w_buf_next;
                    r_acc     <= '0;
                    r_k       <= '0;
                    r_ovf_acc <= r_ovf_acc | w_elem_ovf;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= w_last_i ? '0 : r_i + IW'(1);
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                    if (w_last_i && w_last_j) begin
                        r_res <= w_buf_next;
                        r_ovf <= r_ovf_acc | w_elem_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_mat_seq.sv
// Testbench for mult_mat_seq (default parameters: 2x2 by 2x2, 3-bit elements).
// Stimulus pushes expected result/ovf/latency into a queue; a negedge monitor
// pops and compares whenever done is seen.
module tb_mult_mat_seq;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic        start;
    logic [11:0] matriz_A;
    logic [11:0] matriz_B;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [11:0] matriz_resultado;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [11:0] res;
        logic        ovf;
        int          start_edge;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mult_mat_seq #(.Bit(3), .N(2), .M(2), .P(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_enable       (clk_enable),
        .start            (start),
        .matriz_A         (matriz_A),
        .matriz_B         (matriz_B),
        .busy             (busy),
        .done             (done),
        .ovf              (ovf),
        .matriz_resultado (matriz_resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(matriz_resultado), 32'(e.res));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("done_latency", 32'(edge_cnt - e.start_edge), 32'(e.lat));
            end
        end
    end

    // Caller is at a negedge. stall_at < 0 means no stall.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] exp_res, input logic exp_ovf,
                          input int stall_at, input int stall_len, input bit disturb);
        int  s;
        int  n;
        bit  busy_ok;
        bit  finished;
        exp_t e;
        e.res        = exp_res;
        e.ovf        = exp_ovf;
        e.start_edge = edge_cnt + 1;
        e.lat        = 13 + ((stall_at >= 0) ? stall_len : 0);
        matriz_A = a;
        matriz_B = b;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        s        = edge_cnt;
        busy_ok  = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            n = edge_cnt - s;
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sb.size() == 0) begin
                finished = 1'b1;
            end else begin
                if (stall_at >= 0 && n == stall_at) clk_enable = 1'b0;
                if (stall_at >= 0 && n == stall_at + stall_len) clk_enable = 1'b1;
                if (disturb && n >= 3 && n <= 10) begin
                    start    = ~start;
                    matriz_A = ~a ^ 12'(n);
                end
                if (n == 11) start = 1'b0;
                @(negedge clk);
            end
        end
        start      = 1'b0;
        clk_enable = 1'b1;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
            sb.delete();
        end
        check("busy_during_op", 32'(busy_ok), 32'd1);
        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("no_queued_op", 32'(busy), 32'd0);
    endtask

    localparam logic [11:0] A_ID  = {3'd1, 3'd0, 3'd0, 3'd1};
    localparam logic [11:0] B_ID  = {3'd5, 3'd4, 3'd3, 3'd2};
    localparam logic [11:0] C_ID  = {3'd5, 3'd3, 3'd4, 3'd2};
    localparam logic [11:0] A_G   = {3'd0, 3'd3, 3'd2, 3'd1};
    localparam logic [11:0] B_G   = {3'd3, 3'd1, 3'd1, 3'd2};
    localparam logic [11:0] C_G   = {3'd3, 3'd6, 3'd7, 3'd4};
    localparam logic [11:0] A_P   = {3'd1, 3'd0, 3'd3, 3'd3};
    localparam logic [11:0] B_P   = {3'd2, 3'd0, 3'd0, 3'd3};
    localparam logic [11:0] ALL7  = 12'hFFF;
`ifdef MULT_MAT_SAT_EN
    localparam logic [11:0] C_P   = {3'd2, 3'd0, 3'd6, 3'd7};
    localparam logic [11:0] C_O   = 12'hFFF;
`else
    localparam logic [11:0] C_P   = {3'd2, 3'd0, 3'd6, 3'd1};
    localparam logic [11:0] C_O   = {3'd2, 3'd2, 3'd2, 3'd2};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        clk_enable = 1'b1;
        start      = 1'b0;
        matriz_A   = '0;
        matriz_B   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_result", 32'(matriz_resultado), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(A_ID, B_ID, C_ID, 1'b0, -1, 0, 1'b0);
        run_op(A_G,  B_G,  C_G,  1'b0, -1, 0, 1'b0);
        run_op(A_P,  B_P,  C_P,  1'b1, -1, 0, 1'b0);
        run_op(A_ID, B_ID, C_ID, 1'b0, -1, 0, 1'b0);
        run_op(A_ID, B_ID, C_ID, 1'b0,  4, 5, 1'b0);
        run_op(A_G,  B_G,  C_G,  1'b0, -1, 0, 1'b1);
        run_op(ALL7, ALL7, C_O,  1'b1, -1, 0, 1'b0);

        // Abort an operation during WRITE of C(0,0); outputs must clear at once.
        matriz_A = ALL7;
        matriz_B = ALL7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_result", 32'(matriz_resultado), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(A_ID, B_ID, C_ID, 1'b0, -1, 0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_mat_seq.md
MULT_MAT_SEQ -- requirements
Module: mult_mat_seq

Interface
REQ-001 The block SHALL have parameter Bit, default 3, meaning the width of each matrix element in bits.
REQ-002 The block SHALL have parameter N, default 2, meaning the number of rows of A and of the result.
REQ-003 The block SHALL have parameter M, default 2, meaning the number of columns of A and rows of B; M SHALL be at least 1.
REQ-004 The block SHALL have parameter P, default 2, meaning the number of columns of B and of the result.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clk_enable, input, 1 bit: when low, all state (FSM, counters, accumulator, registers) holds.
REQ-008 The block SHALL have port start, input, 1 bit: requests one multiplication.
REQ-009 The block SHALL have port matriz_A, input, Bit*N*M bits: element A(i,k) at bits [(i*M+k)*Bit +: Bit].
REQ-010 The block SHALL have port matriz_B, input, Bit*M*P bits: element B(k,j) at bits [(j*M+k)*Bit +: Bit] (column-major).
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-013 The block SHALL have port ovf, output, 1 bit: set when any element of the last result exceeded 2^Bit-1.
REQ-014 The block SHALL have port matriz_resultado, output, Bit*N*P bits: element C(i,j) at bits [(i*P+j)*Bit +: Bit].

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, MAC, WRITE and DONE; all transitions below occur only on enabled edges (clk_enable=1).
REQ-016 In IDLE with start=1, the FSM SHALL go to LOAD; with start=0, it SHALL stay in IDLE.
REQ-017 In LOAD, the block SHALL capture matriz_A and matriz_B into internal registers, clear the accumulator, set i=j=k=0, and go to MAC; later input changes SHALL NOT affect the operation in progress.
REQ-018 In MAC, the block SHALL perform acc <= acc + A(i,k)*B(k,j) and increment k; when k=M-1 it SHALL go to WRITE, so exactly M MAC edges occur per element.
REQ-019 In WRITE, the block SHALL store the reduced acc into the internal result buffer at C(i,j), clear acc and k, and advance j, wrapping j to 0 and incrementing i.
REQ-020 After writing C(N-1,P-1), WRITE SHALL go to DONE; otherwise it SHALL return to MAC.
REQ-021 On entry to DONE, matriz_resultado and ovf SHALL be updated atomically from the buffer; they SHALL hold their values at all other times.
REQ-022 done SHALL be high only while in DONE; DONE SHALL go to IDLE on the next enabled edge, making done exactly one enabled cycle long.
REQ-023 done SHALL rise N*P*(M+1)+1 enabled edges after the edge that sampled start (13 edges for the default parameters).
REQ-024 Unsigned arithmetic SHALL be used throughout; acc SHALL be 2*Bit+clog2(M+1) bits wide so that it never wraps.
REQ-025 Reduction SHALL keep the Bit LSBs of acc (modulo 2^Bit) unless SAT_EN applies (see Configuration).
REQ-026 ovf SHALL be the OR, over all elements of the operation, of (acc > 2^Bit-1).
REQ-027 start asserted in LOAD, MAC, WRITE or DONE SHALL be ignored and SHALL NOT be queued.
REQ-028 A clk_enable low period of any length SHALL delay every subsequent event, including done, by exactly that many cycles.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, i=j=k=0, acc=0, the result buffer to 0, matriz_resultado=0, busy=0, done=0 and ovf=0.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; the first enabled edge after rst_n rises SHALL be able to sample start.

Configuration
REQ-031 When macro MULT_MAT_SAT_EN is defined, reduction SHALL saturate: any acc > 2^Bit-1 yields 2^Bit-1.
REQ-032 When MULT_MAT_SAT_EN is undefined, reduction SHALL truncate to the Bit LSBs.
REQ-033 ovf behaviour SHALL be identical with or without MULT_MAT_SAT_EN.

Verification
REQ-034 Identity test: A=(A00=1,A01=0,A10=0,A11=1), B=(B00=2,B10=3,B01=4,B11=5), start pulsed -> done at edge 13; C00=2, C01=4, C10=3, C11=5; ovf=0.
REQ-035 Overflow test: all elements of A and B = 7 -> each acc=98; without MULT_MAT_SAT_EN every C=2, with MULT_MAT_SAT_EN every C=7; ovf=1 in both builds.
REQ-036 Stall test: clk_enable=0 for 5 cycles during MAC of C(0,1) -> done at edge 18 with results identical to the unstalled run.
REQ-037 Busy-start and input-change test: start re-pulsed and matriz_A changed in cycles 3-10 -> no second operation, results computed from the captured operands, busy=1 from edge 1 through DONE.
REQ-038 Reset test: rst_n pulsed low during WRITE -> outputs 0 asynchronously, no done; a new start then completes normally at edge 13.
